fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_sequencer_if.sv | 35 +++
 rtl/fetch_sequencer_pc_reg.sv | 39 +++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// default bus widths, opcode field position and the wrapping pc adder.
package fetch_pkg;

    localparam int ADDR_W     = 8;
    localparam int INST_W     = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Sum wraps naturally at 2^ADDR_W (8'hFE + 2 -> 8'h00).
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc,
                                                  input logic [ADDR_W-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer (master) and the memory/decode side (slave).
//
// Handshake: there is no ready; the sequencer only advances on clk_en. On each
// clk_en step, inst_valid=1 means inst_out holds a freshly fetched instruction
// that decode must consume in that step; inst_valid=0 means inst_out must be
// ignored (prime, flush, stall-after-flush or halt). state is a debug view of
// the sequencer FSM.
interface fetch_sequencer_if;
    import fetch_pkg::*;

    logic                clk_en;
    logic                stall;
    logic                branch_taken;
    logic [ADDR_W-1:0]   branch_target;
    logic                halt_req;
    logic                resume;
    logic [INST_W-1:0]   inst_in;
    logic [ADDR_W-1:0]   pc_out;
    logic [INST_W-1:0]   inst_out;
    logic                inst_valid;
    logic                halted;
    logic                fault;
    fetch_state_e        state;

    modport master (
        input  clk_en, stall, branch_taken, branch_target, halt_req, resume, inst_in,
        output pc_out, inst_out, inst_valid, halted, fault, state
    );

    modport slave (
        output clk_en, stall, branch_taken, branch_target, halt_req, resume, inst_in,
        input  pc_out, inst_out, inst_valid, halted, fault, state
    );

endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register: load has priority over increment, otherwise hold.
// Only updates on the enable strobe; asynchronous active-low reset.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] STEP     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc_q
);

    logic [ADDR_W-1:0] pc_d;

    // Next pc: redirect, step, or hold.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = next_pc(pc_q, STEP);
        end
    end

    // PC flop, advanced only on the processor step strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (en) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the instruction memory address, captures the
// returned word one step later and hands it to decode with a valid flag.
// Handles sequential stepping, taken branches (one-slot flush), stalls,
// halt/resume and sticky out-of-range faults.
// Optional build macro FETCH_HALT_ON_OPCODE_EN: capturing a word whose opcode
// equals HALT_OPCODE delivers it to decode and then enters HALT.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
    parameter logic [ADDR_W-1:0] PC_STEP     = 8'd2,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = 8'd64,
    parameter logic [3:0]        HALT_OPCODE = 4'hC
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] pc_q;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_load_val;

    logic              unused_tgt_lsb;
    assign unused_tgt_lsb = bus.branch_target[0];

`ifdef FETCH_HALT_ON_OPCODE_EN
    logic halt_op;
    assign halt_op = (bus.inst_in[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
`else
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
`endif

    pc_reg #(
        .RESET_PC (RESET_PC),
        .STEP     (PC_STEP)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.clk_en),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (pc_load_val),
        .pc_q     (pc_q)
    );

    // FSM next-state and output decisions; RUN priority is
    // halt_req > out-of-range > branch > stall > sequential.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        fault_d     = fault_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load_val = {bus.branch_target[ADDR_W-1:1], 1'b0};

        unique case (state_q)
            PRIME: begin
                // Memory has just been given pc; nothing to capture yet.
                valid_d  = 1'b0;
                halted_d = 1'b0;
                state_d  = RUN;
            end
            RUN: begin
                if (bus.halt_req) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (pc_q > MAX_ADDR) begin
                    fault_d  = 1'b1;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (bus.branch_taken) begin
                    // Wrong-path word is dropped; inst_out keeps its old value.
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                end else if (bus.stall) begin
                    // Everything holds.
                    valid_d = valid_q;
                end else begin
                    inst_d  = bus.inst_in;
                    valid_d = 1'b1;
                    pc_inc  = 1'b1;
`ifdef FETCH_HALT_ON_OPCODE_EN
                    // The halt word itself still reaches decode this step;
                    // pc then freezes at the address after it.
                    if (halt_op) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
`endif
                end
            end
            HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
                if (bus.resume) begin
                    pc_load     = 1'b1;
                    pc_load_val = RESET_PC;
                    fault_d     = 1'b0;
                    halted_d    = 1'b0;
                    state_d     = PRIME;
                end
            end
            default: begin
                valid_d  = 1'b0;
                halted_d = 1'b0;
                state_d  = PRIME;
            end
        endcase
    end

    // FSM and registered outputs, stepped only on clk_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PRIME;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (bus.clk_en) begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.pc_out     = pc_q;
    assign bus.inst_out   = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.halted     = halted_q;
    assign bus.fault      = fault_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (default MAX_ADDR=64 and
// MAX_ADDR=8'hFF) driven with identical stimulus, a negedge-read instruction
// memory, and a per-instance reference model of the fetch rules.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;

    fetch_sequencer_if if_a ();
    fetch_sequencer_if if_b ();

    fetch_sequencer u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.master)
    );

    fetch_sequencer #(.MAX_ADDR(8'hFF)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.master)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- instruction memory ----------------
    logic [15:0] mem [128];

    always @(negedge clk) begin
        if_a.inst_in = mem[if_a.pc_out[7:1]];
        if_b.inst_in = mem[if_b.pc_out[7:1]];
    end

    // ---------------- reference model ----------------
    int m_pc [2];
    int m_inst [2];
    int m_valid [2];
    int m_halted [2];
    int m_fault [2];
    int m_mode [2];          // 0 = prime, 1 = run, 2 = halt
    int m_max [2] = '{64, 255};

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 0; m_inst[i] = 0; m_valid[i] = 0;
            m_halted[i] = 0; m_fault[i] = 0; m_mode[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit hr, input bit br,
                              input bit st, input bit rs, input int tgt);
        int w;
        if (m_mode[i] == 0) begin
            m_valid[i] = 0;
            m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
            if (hr) begin
                m_valid[i] = 0; m_halted[i] = 1; m_mode[i] = 2;
            end else if (m_pc[i] > m_max[i]) begin
                m_fault[i] = 1; m_valid[i] = 0; m_halted[i] = 1; m_mode[i] = 2;
            end else if (br) begin
                m_pc[i] = tgt - (tgt % 2);
                m_valid[i] = 0;
            end else if (!st) begin
                w = int'(mem[m_pc[i] / 2]);
                m_inst[i] = w;
                m_valid[i] = 1;
                m_pc[i] = (m_pc[i] + 2) % 256;
`ifdef FETCH_HALT_ON_OPCODE_EN
                if ((w >> 12) == 12) begin
                    m_halted[i] = 1; m_mode[i] = 2;
                end
`endif
            end
        end else begin
            m_valid[i] = 0;
            if (rs) begin
                m_pc[i] = 0; m_fault[i] = 0; m_halted[i] = 0; m_mode[i] = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_state(input int mode);
        fetch_state_e s;
        s = (mode == 0) ? PRIME : (mode == 1) ? RUN : HALT;
        return 32'(s);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string p);
        chk({p, "_a_pc"},     32'(if_a.pc_out),     m_pc[0]);
        chk({p, "_a_inst"},   32'(if_a.inst_out),   m_inst[0]);
        chk({p, "_a_valid"},  32'(if_a.inst_valid), m_valid[0]);
        chk({p, "_a_halted"}, 32'(if_a.halted),     m_halted[0]);
        chk({p, "_a_fault"},  32'(if_a.fault),      m_fault[0]);
        chk({p, "_a_state"},  32'(if_a.state),      exp_state(m_mode[0]));
        chk({p, "_b_pc"},     32'(if_b.pc_out),     m_pc[1]);
        chk({p, "_b_inst"},   32'(if_b.inst_out),   m_inst[1]);
        chk({p, "_b_valid"},  32'(if_b.inst_valid), m_valid[1]);
        chk({p, "_b_halted"}, 32'(if_b.halted),     m_halted[1]);
        chk({p, "_b_fault"},  32'(if_b.fault),      m_fault[1]);
        chk({p, "_b_state"},  32'(if_b.state),      exp_state(m_mode[1]));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit en, input bit hr, input bit br, input bit st,
                         input bit rs, input int tgt);
        if_a.clk_en = en; if_a.halt_req = hr; if_a.branch_taken = br;
        if_a.stall = st; if_a.resume = rs; if_a.branch_target = 8'(tgt);
        if_b.clk_en = en; if_b.halt_req = hr; if_b.branch_taken = br;
        if_b.stall = st; if_b.resume = rs; if_b.branch_target = 8'(tgt);
    endtask

    task automatic step(input bit hr, input bit br, input bit st, input bit rs,
                        input int tgt, input string tag);
        @(negedge clk);
        #1;
        drive(1'b1, hr, br, st, rs, tgt);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        model_step(0, hr, br, st, rs, tgt);
        model_step(1, hr, br, st, rs, tgt);
        check_all(tag);
    endtask

    // Clock cycle with clk_en low and random side inputs: nothing may move.
    task automatic idle();
        @(negedge clk);
        #1;
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_all("idle");
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int saved_pc;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom_range(0, 65535));
        mem[8'h3C / 2] = 16'h1234;
        mem[8'h3E / 2] = 16'h2345;
        mem[8'h40 / 2] = 16'hC000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        if_a.inst_in = '0;
        if_b.inst_in = '0;
        rst_n = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Sequential start: pc 00,00,02,04,06.
        step(0, 0, 0, 0, 0, "prime");
        chk("prime_pc", 32'(if_a.pc_out), 32'h00);
        chk("prime_valid", 32'(if_a.inst_valid), 0);
        repeat (3) step(0, 0, 0, 0, 0, "seq");
        chk("seq_pc", 32'(if_a.pc_out), 32'h06);
        chk("seq_inst", 32'(if_a.inst_out), 32'(mem[2]));

        // Branch at 0x14 to 0x25 -> 0x24 with one flushed slot.
        for (int k = 0; k < 20 && m_pc[0] != 8'h14; k++) step(0, 0, 0, 0, 0, "to14");
        step(0, 1, 0, 0, 8'h25, "br");
        chk("br_pc", 32'(if_a.pc_out), 32'h24);
        chk("br_valid", 32'(if_a.inst_valid), 0);
        step(0, 0, 0, 0, 0, "br_next");
        chk("br_word", 32'(if_a.inst_out), 32'(mem[8'h24 / 2]));
        chk("br_word_valid", 32'(if_a.inst_valid), 1);

        // Stall three steps at 0x0A.
        step(0, 1, 0, 0, 8'h08, "br08");
        step(0, 0, 0, 0, 0, "to0a");
        repeat (3) step(0, 0, 1, 0, 0, "stall");
        chk("stall_pc", 32'(if_a.pc_out), 32'h0A);
        chk("stall_inst", 32'(if_a.inst_out), 32'(mem[8'h08 / 2]));
        step(0, 0, 0, 0, 0, "unstall");
        chk("unstall_pc", 32'(if_a.pc_out), 32'h0C);

        // Run past MAX_ADDR on instance a.
        step(0, 1, 0, 0, 8'h3E, "br3e");
        for (int k = 0; k < 10 && m_halted[0] == 0; k++) step(0, 0, 0, 0, 0, "tofault");
`ifndef FETCH_HALT_ON_OPCODE_EN
        chk("oor_fault", 32'(if_a.fault), 1);
        chk("oor_halted", 32'(if_a.halted), 1);
        chk("oor_pc", 32'(if_a.pc_out), 32'h42);
        chk("oor_valid", 32'(if_a.inst_valid), 0);
`endif
        step(0, 0, 0, 1, 0, "resume");
        chk("res_pc", 32'(if_a.pc_out), 32'h00);
        chk("res_fault", 32'(if_a.fault), 0);
        chk("res_state", 32'(if_a.state), 32'(PRIME));

        // Wrap from 0xFE to 0x00 on instance b.
        step(0, 0, 0, 0, 0, "pre_wrap");
        step(0, 1, 0, 0, 8'hFE, "brfe");
        step(0, 0, 0, 0, 0, "wrap");
        chk("wrap_b_pc", 32'(if_b.pc_out), 32'h00);
        chk("wrap_b_fault", 32'(if_b.fault), 0);

        // halt_req and branch together: halt wins, pc unchanged.
        step(0, 0, 0, 1, 0, "res2");
        step(0, 0, 0, 0, 0, "run2");
        saved_pc = m_pc[1];
        step(1, 1, 0, 0, 8'h30, "halt_br");
        chk("hb_halted", 32'(if_b.halted), 1);
        chk("hb_pc", 32'(if_b.pc_out), 32'(saved_pc));
        step(0, 0, 0, 1, 0, "res3");

        // Randomized phase with idle cycles between steps.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                step(1'($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 6) == 0),
                     1'($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 72),
                     "rnd");
            end
        end

        // Asynchronous reset between clock edges, with clk_en high.
        @(posedge clk);
        #3;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, "post_arst");

`ifdef FETCH_HALT_ON_OPCODE_EN
        // Halt opcode at 0x40 delivered, then pc frozen at 0x42.
        step(0, 1, 0, 0, 8'h3C, "br3c");
        for (int k = 0; k < 10 && m_halted[0] == 0; k++) step(0, 0, 0, 0, 0, "tohop");
        chk("hop_inst", 32'(if_a.inst_out), 32'hC000);
        chk("hop_valid", 32'(if_a.inst_valid), 1);
        chk("hop_pc", 32'(if_a.pc_out), 32'h42);
        step(0, 0, 0, 0, 0, "hop_hold");
        chk("hop_halted", 32'(if_a.halted), 1);
        chk("hop_pc_hold", 32'(if_a.pc_out), 32'h42);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
